// File: rtl/wb_disp_capture_pkg.sv
// Shared types for the writeback display capture block: register word,
// register address, display FSM states and the capture qualifier.
package wb_disp_capture_pkg;

  typedef logic [31:0] Reg_t;
  typedef logic [4:0]  RegAddr_t;

  // EMPTY: nothing shown since reset. SHOW: a value is on the display.
  typedef enum logic {
    EMPTY = 1'b0,
    SHOW  = 1'b1
  } disp_state_t;

  // A writeback is interesting only when it targets the watched register;
  // $0 is hardwired to zero in the CPU, so writes to it are never shown.
  function automatic logic is_capture(input logic     we,
                                      input RegAddr_t waddr,
                                      input RegAddr_t sel);
    return we && (waddr == sel) && (waddr != '0);
  endfunction

endpackage

// File: rtl/disp_fifo.sv
// Small pending-value queue for the display. A pop and a push in the same
// cycle are both honoured even when full, so the occupancy stays constant.
module disp_fifo
  import wb_disp_capture_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [31:0]              push_data,
  output logic [31:0]              head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_COUNT = (PW+1)'(DEPTH);

  Reg_t          mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          do_pop;
  logic          do_push;

  assign empty   = (count == '0);
  assign full    = (count == FULL_COUNT);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // Storage array; contents need no reset because the pointers gate reads.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two; count tracks occupancy.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/wb_disp_capture.sv
// Captures CPU writebacks to a selected register and shows each captured
// value on the display for at least HOLD_CYCLES cycles, queueing the rest.
module wb_disp_capture
  import wb_disp_capture_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 50_000_000,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wb_we,
  input  logic [4:0]                    wb_waddr,
  input  logic [31:0]                   wb_wdata,
  input  logic [4:0]                    sel_reg,
  input  logic                          step,
  input  logic                          freeze,
  input  logic                          ovf_clr,
  output logic [31:0]                   disp_value,
  output logic                          disp_valid,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);

  localparam logic [31:0] HOLD_MAX = 32'(HOLD_CYCLES - 1);

  disp_state_t state;
  disp_state_t state_next;
  logic [31:0] hold_cnt;
  logic        capture;
  logic        aged;
  logic        load_first;
  logic        bypass;
  logic        pop;
  logic        push;
  logic        drop;
  Reg_t        fifo_head;
  logic        fifo_full;
  logic        fifo_empty;

  assign capture = is_capture(wb_we, wb_waddr, sel_reg);

  disp_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .push_data (wb_wdata),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= EMPTY;
    end else begin
      state <= state_next;
    end
  end

  // Leave EMPTY on the first capture; SHOW is permanent until reset.
  always_comb begin
    state_next = state;
    if (state == EMPTY && capture) begin
      state_next = SHOW;
    end
  end

  // Decide whether this cycle loads the display from the queue, directly from the bus, or queues.
  always_comb begin
    aged       = 1'b0;
    load_first = 1'b0;
    bypass     = 1'b0;
    pop        = 1'b0;
    push       = 1'b0;
    case (state)
      EMPTY: begin
        load_first = capture;
      end
      SHOW: begin
        aged = (hold_cnt == HOLD_MAX) || (step && !freeze);
        if (!freeze && aged) begin
          if (!fifo_empty) begin
            pop = 1'b1;
          end else if (capture) begin
            bypass = 1'b1;
          end
        end
        push = capture && !bypass;
      end
      default: begin
        load_first = 1'b0;
      end
    endcase
    drop = push && fifo_full && !pop;
  end

  // Display register, hold counter and sticky overflow; a drop beats a clear.
  always_ff @(posedge clk) begin
    if (!rst) begin
      disp_value <= '0;
      disp_valid <= 1'b0;
      hold_cnt   <= '0;
      overflow   <= 1'b0;
    end else begin
      if (load_first || bypass) begin
        disp_value <= wb_wdata;
        disp_valid <= 1'b1;
        hold_cnt   <= '0;
      end else if (pop) begin
        disp_value <= fifo_head;
        hold_cnt   <= '0;
      end else if (state == SHOW && !freeze && hold_cnt != HOLD_MAX) begin
        hold_cnt <= hold_cnt + 32'd1;
      end
      if (drop) begin
        overflow <= 1'b1;
      end else if (ovf_clr) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_wb_disp_capture.sv
// Bench for wb_disp_capture: two instances (short and long hold) share one
// stimulus stream and are compared every cycle against a list-based model.
module tb_wb_disp_capture;
  import wb_disp_capture_pkg::*;

  localparam int DEPTH  = 4;
  localparam int HOLD_A = 4;
  localparam int HOLD_B = 100;

  logic     clk = 1'b0;
  logic     rst, wb_we, step, freeze, ovf_clr;
  RegAddr_t wb_waddr, sel_reg;
  Reg_t     wb_wdata;

  Reg_t       disp_a, disp_b;
  logic       valid_a, valid_b, ovf_a, ovf_b;
  logic [2:0] count_a, count_b;

  int checks = 0;
  int errors = 0;

  // Reference model state, one slot per instance.
  bit   m_shown [2];
  Reg_t m_disp  [2];
  int   m_age   [2];
  bit   m_ovf   [2];
  Reg_t m_q     [2][DEPTH];
  int   m_len   [2];
  int   m_hold  [2];

  always #5 clk = ~clk;

  wb_disp_capture #(.HOLD_CYCLES(HOLD_A), .FIFO_DEPTH(DEPTH)) dut_a (
    .clk(clk), .rst(rst), .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
    .sel_reg(sel_reg), .step(step), .freeze(freeze), .ovf_clr(ovf_clr),
    .disp_value(disp_a), .disp_valid(valid_a), .fifo_count(count_a), .overflow(ovf_a));

  wb_disp_capture #(.HOLD_CYCLES(HOLD_B), .FIFO_DEPTH(DEPTH)) dut_b (
    .clk(clk), .rst(rst), .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
    .sel_reg(sel_reg), .step(step), .freeze(freeze), .ovf_clr(ovf_clr),
    .disp_value(disp_b), .disp_valid(valid_b), .fifo_count(count_b), .overflow(ovf_b));

  // Behavioural model: the queue is an ordered list, the hold is an age in cycles.
  task automatic model_step(input int k);
    bit cap, aged, take_head, take_new, dropped;
    cap = wb_we && (wb_waddr == sel_reg) && (wb_waddr != 0);
    dropped = 0;
    if (!rst) begin
      m_shown[k] = 0; m_disp[k] = 0; m_age[k] = 0; m_ovf[k] = 0; m_len[k] = 0;
      return;
    end
    if (!m_shown[k]) begin
      if (cap) begin
        m_shown[k] = 1; m_disp[k] = wb_wdata; m_age[k] = 0;
      end
    end else begin
      aged      = (m_age[k] >= m_hold[k] - 1) || (step && !freeze);
      take_head = !freeze && aged && (m_len[k] > 0);
      take_new  = !freeze && aged && (m_len[k] == 0) && cap;
      if (take_head) begin
        m_disp[k] = m_q[k][0];
        for (int i = 1; i < m_len[k]; i++) m_q[k][i-1] = m_q[k][i];
        m_len[k]--;
        m_age[k] = 0;
      end else if (take_new) begin
        m_disp[k] = wb_wdata;
        m_age[k]  = 0;
      end else if (!freeze && m_age[k] < m_hold[k] - 1) begin
        m_age[k]++;
      end
      if (cap && !take_new) begin
        if (m_len[k] < DEPTH) begin
          m_q[k][m_len[k]] = wb_wdata;
          m_len[k]++;
        end else begin
          dropped = 1;
        end
      end
    end
    if (dropped) m_ovf[k] = 1;
    else if (ovf_clr) m_ovf[k] = 0;
  endtask

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_output();
    check_val("a_disp",  disp_a,  m_disp[0]);
    check_val("a_valid", 32'(valid_a), 32'(m_shown[0]));
    check_val("a_count", 32'(count_a), 32'(m_len[0]));
    check_val("a_ovf",   32'(ovf_a),   32'(m_ovf[0]));
    check_val("b_disp",  disp_b,  m_disp[1]);
    check_val("b_valid", 32'(valid_b), 32'(m_shown[1]));
    check_val("b_count", 32'(count_b), 32'(m_len[1]));
    check_val("b_ovf",   32'(ovf_b),   32'(m_ovf[1]));
  endtask

  // One clock: update the model from the applied inputs, then compare after the edge.
  task automatic tick();
    model_step(0);
    model_step(1);
    @(posedge clk);
    #1;
    check_output();
    rst = 1'b1; wb_we = 1'b0; step = 1'b0; ovf_clr = 1'b0;
  endtask

  task automatic wb_write(input RegAddr_t a, input Reg_t d);
    wb_we = 1'b1; wb_waddr = a; wb_wdata = d;
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b0; freeze = 1'b0;
    tick();
  endtask

  task automatic expect_reset_outputs(input string tag);
    check_val({tag, "_disp_a"},  disp_a, 32'h0);
    check_val({tag, "_valid_a"}, 32'(valid_a), 32'd0);
    check_val({tag, "_count_a"}, 32'(count_a), 32'd0);
    check_val({tag, "_ovf_a"},   32'(ovf_a), 32'd0);
    check_val({tag, "_disp_b"},  disp_b, 32'h0);
    check_val({tag, "_count_b"}, 32'(count_b), 32'd0);
  endtask

  initial begin
    m_hold[0] = HOLD_A;
    m_hold[1] = HOLD_B;
    for (int k = 0; k < 2; k++) begin
      m_shown[k] = 0; m_disp[k] = 0; m_age[k] = 0; m_ovf[k] = 0; m_len[k] = 0;
    end
    rst = 1'b1; wb_we = 1'b0; wb_waddr = '0; wb_wdata = '0;
    sel_reg = 5'd2; step = 1'b0; freeze = 1'b0; ovf_clr = 1'b0;

    // Bypass from EMPTY: value visible one cycle after capture.
    do_reset();
    expect_reset_outputs("rst0");
    wb_write(5'd2, 32'h1234_5678);
    check_val("bypass_disp",  disp_a, 32'h1234_5678);
    check_val("bypass_valid", 32'(valid_a), 32'd1);

    // Hold and queue: A, B, C back to back, four-cycle hold.
    do_reset();
    wb_write(5'd2, 32'hAAAA_0001);
    check_val("hq_a_shown", disp_a, 32'hAAAA_0001);
    wb_write(5'd2, 32'hBBBB_0002);
    check_val("hq_count1", 32'(count_a), 32'd1);
    wb_write(5'd2, 32'hCCCC_0003);
    check_val("hq_count2", 32'(count_a), 32'd2);
    tick();
    check_val("hq_a_held", disp_a, 32'hAAAA_0001);
    tick();
    check_val("hq_b_shown", disp_a, 32'hBBBB_0002);
    check_val("hq_count3",  32'(count_a), 32'd1);
    repeat (3) tick();
    check_val("hq_b_held", disp_a, 32'hBBBB_0002);
    tick();
    check_val("hq_c_shown", disp_a, 32'hCCCC_0003);
    check_val("hq_count4",  32'(count_a), 32'd0);

    // Overflow on the long-hold instance: six captures, the sixth is dropped.
    do_reset();
    for (int i = 0; i < 6; i++) wb_write(5'd2, 32'hD000_0000 + 32'(i));
    check_val("ovf_first",  disp_b, 32'hD000_0000);
    check_val("ovf_count",  32'(count_b), 32'd4);
    check_val("ovf_set",    32'(ovf_b), 32'd1);
    ovf_clr = 1'b1;
    wb_write(5'd2, 32'hD000_0006);
    check_val("ovf_set_wins", 32'(ovf_b), 32'd1);
    check_val("ovf_count_kept", 32'(count_b), 32'd4);
    ovf_clr = 1'b1;
    tick();
    check_val("ovf_cleared", 32'(ovf_b), 32'd0);
    step = 1'b1;
    wb_write(5'd2, 32'hE000_0000);
    check_val("full_pp_disp",  disp_b, 32'hD000_0001);
    check_val("full_pp_count", 32'(count_b), 32'd4);
    check_val("full_pp_ovf",   32'(ovf_b), 32'd0);
    for (int i = 2; i < 5; i++) begin
      step = 1'b1;
      tick();
      check_val("order", disp_b, 32'hD000_0000 + 32'(i));
    end
    step = 1'b1;
    tick();
    check_val("order_last", disp_b, 32'hE000_0000);

    // Filters and freeze.
    do_reset();
    sel_reg = 5'd0;
    wb_write(5'd0, 32'h0BAD_0000);
    check_val("zero_reg_ignored", 32'(valid_a), 32'd0);
    sel_reg = 5'd2;
    wb_write(5'd3, 32'h0BAD_0003);
    check_val("other_reg_ignored", 32'(valid_a), 32'd0);
    wb_write(5'd2, 32'hE1E1_E1E1);
    freeze = 1'b1;
    wb_write(5'd2, 32'hF1F1_F1F1);
    wb_write(5'd2, 32'hF2F2_F2F2);
    repeat (8) tick();
    check_val("freeze_disp",  disp_a, 32'hE1E1_E1E1);
    check_val("freeze_count", 32'(count_a), 32'd2);
    freeze = 1'b0;
    repeat (3) tick();
    check_val("thaw_hold", disp_a, 32'hE1E1_E1E1);
    tick();
    check_val("thaw_pop", disp_a, 32'hF1F1_F1F1);

    // Step and reset with a non-empty queue.
    do_reset();
    wb_write(5'd2, 32'h1111_1111);
    wb_write(5'd2, 32'h2222_2222);
    step = 1'b1;
    tick();
    check_val("step_pop", disp_a, 32'h2222_2222);
    wb_write(5'd2, 32'h3333_3333);
    wb_write(5'd2, 32'h4444_4444);
    wb_write(5'd2, 32'h5555_5555);
    check_val("pre_rst_count", 32'(count_a), 32'd3);
    rst = 1'b0;
    wb_write(5'd2, 32'h6666_6666);
    expect_reset_outputs("rst_mid");

    // Randomized traffic checked cycle by cycle against the model.
    for (int n = 0; n < 600; n++) begin
      wb_we    = ($urandom_range(0, 1) == 1);
      wb_waddr = RegAddr_t'($urandom_range(0, 3));
      wb_wdata = $urandom;
      if ($urandom_range(0, 15) == 0) sel_reg = RegAddr_t'($urandom_range(0, 2));
      step     = ($urandom_range(0, 19) == 0);
      ovf_clr  = ($urandom_range(0, 19) == 0);
      freeze   = m_shown[0] && ($urandom_range(0, 7) == 0);
      rst      = ($urandom_range(0, 149) != 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_disp_capture.md
WB_DISP_CAPTURE -- requirements
Module: wb_disp_capture

Interface
REQ-001 Parameter HOLD_CYCLES, default 50_000_000, minimum display time of each value in clk cycles (legal range 2..2^32-1).
REQ-002 Parameter FIFO_DEPTH, default 4, pending-value queue depth (power of two, 2..16).
REQ-003 clk  in  1  single system clock, all state changes on rising edge.
REQ-004 rst  in  1  synchronous active-low reset, rst==0 sampled at a rising clk edge resets the block.
REQ-005 wb_we  in  1  CPU register-file writeback enable.
REQ-006 wb_waddr  in  5  writeback destination register.
REQ-007 wb_wdata  in  32  writeback data.
REQ-008 sel_reg  in  5  register number to watch.
REQ-009 step  in  1  single-cycle pulse, ends the current hold early.
REQ-010 freeze  in  1  level, stops the hold counter and all pops while high.
REQ-011 ovf_clr  in  1  single-cycle pulse, clears overflow.
REQ-012 disp_value  out  32  value driven to the seven-segment decode chain.
REQ-013 disp_valid  out  1  high once any value has been displayed since reset.
REQ-014 fifo_count  out  $clog2(FIFO_DEPTH)+1  number of queued values.
REQ-015 overflow  out  1  sticky flag, a capture was dropped.

Function
REQ-016 A capture is the condition wb_we==1 && wb_waddr==sel_reg && wb_waddr!=0. Writes to $0 are never captured.
REQ-017 The FSM has two states: EMPTY, where nothing has been shown since reset, and SHOW. A 32-bit hold counter runs only in SHOW.
REQ-018 EMPTY: a capture in cycle N loads disp_value in cycle N+1, sets disp_valid, clears the hold counter, and moves to SHOW. The FIFO is bypassed.
REQ-019 SHOW: the hold counter increments each cycle while freeze==0 and saturates at HOLD_CYCLES-1. At saturation the state is "aged".
REQ-020 SHOW, aged, FIFO non-empty, freeze==0: the FIFO head is popped into disp_value on the next edge and the counter is cleared.
REQ-021 SHOW, aged, FIFO empty: a capture bypasses to disp_value in cycle N+1 and the counter is cleared. Otherwise disp_value holds.
REQ-022 SHOW, not aged: a capture is pushed to the FIFO tail.
REQ-023 step==1 with freeze==0 forces aged for that cycle.
REQ-024 freeze==1 blocks pops and bypasses. Captures are still pushed to the FIFO.
REQ-025 Capture while FIFO full with no pop in the same cycle: the new value is dropped, overflow is set, and FIFO contents are unchanged.
REQ-026 Capture and pop in the same cycle while full: the pop occurs, the push occurs, fifo_count is unchanged, and overflow is not set.
REQ-027 ovf_clr clears overflow. If a drop occurs in the same cycle as ovf_clr, overflow remains set because set wins.
REQ-028 Read and write pointers wrap modulo FIFO_DEPTH. FIFO order is strict FIFO.
REQ-029 All outputs are registered. There is no combinational path from any input to any output.

Reset
REQ-030 When rst==0 at an edge, the following reset: disp_value=32'h0, disp_valid=0, fifo_count=0, overflow=0, state=EMPTY, hold counter=0, both pointers=0.
REQ-031 Reset mid-hold or with a non-empty FIFO discards all queued values. Captures present during the reset cycle are ignored.

Structure
REQ-032 The shared defines package holds the Reg_t (32-bit) and RegAddr_t (5-bit) typedefs and the FSM state enum disp_state_t.
REQ-033 The FIFO is one sub-module, disp_fifo, with push/pop/full/empty/count ports. The FSM, hold counter, and bypass logic live in wb_disp_capture.
REQ-034 disp_value connects directly to the eight led_anode nibble decoders in the SOPC top.

Verification
REQ-035 Bypass scenario, HOLD_CYCLES=4: after reset, capture $2=32'h1234_5678 with sel_reg=2 -> disp_value=32'h1234_5678 and disp_valid=1 exactly one cycle later.
REQ-036 Hold and queue scenario, HOLD_CYCLES=4: captures of A, B, C on consecutive cycles -> A shown, B shown 4 cycles after A, C shown 4 cycles after B, fifo_count sequence 1,2,1,0.
REQ-037 Overflow scenario, FIFO_DEPTH=4, HOLD_CYCLES=100: 6 back-to-back captures -> first shown, next 4 queued, sixth dropped, overflow=1; ovf_clr pulse -> overflow=0.
REQ-038 Filter and freeze scenario: a wb_waddr=0 write with sel_reg=0 is not captured. A write to $3 with sel_reg=2 is ignored. With freeze=1 held for 10 cycles, disp_value is unchanged, the queue grows, and after release pops resume.
REQ-039 Step and reset scenario: step while not aged with 1 queued value -> value shown on the next cycle. rst=0 asserted with 3 queued values -> all outputs return to reset values on the following cycle.
